// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and width helpers
// used to size the bit-index and baud-counter registers from the frame
// parameters.
package uart_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_t;

  // Bit index must hold 0..width (data bits) and the stop-bit count.
  function automatic int unsigned bit_idx_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  // Baud counter counts 0..clks-1; keep at least one bit.
  function automatic int unsigned baud_cnt_width(input int unsigned clks);
    return (clks < 2) ? 1 : $clog2(clks);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
//   clk        clock
//   rst_n      asynchronous active-low reset
//   clr_i      synchronous clear; holds the counter at 0 while high
//   bit_end_o  high during the last clock of each bit period
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  output logic bit_end_o
);

  localparam int unsigned CntW = baud_cnt_width(CLKS_PER_BIT);
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  assign bit_end_o = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q + CntW'(1);
    if (clr_i || bit_end_o) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART serial transmitter. Accepts one word per valid/ready handshake and
// sends start bit, WIDTH data bits MSB first, optional parity, and 1 or 2
// stop bits, each held for CLKS_PER_BIT clocks.
//   clk         clock
//   rst_n       asynchronous active-low reset (abandons any frame)
//   tx_data_i   word to send, sampled only on handshake
//   tx_valid_i  upstream has a word
//   tx_ready_o  high only while idle
//   tx_o        serial line, idle high
//   busy_o      frame in progress
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter bit          PARITY_EN    = 1'b1,
  parameter bit          PARITY_ODD   = 1'b0,
  parameter int unsigned STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] tx_data_i,
  input  logic             tx_valid_i,
  output logic             tx_ready_o,
  output logic             tx_o,
  output logic             busy_o
);

  localparam int unsigned IdxW = bit_idx_width(WIDTH);

  tx_state_t        state_d, state_q;
  logic [WIDTH-1:0] shift_d, shift_q;
  logic [IdxW-1:0]  idx_d, idx_q;
  logic             par_d, par_q;
  logic             tx_d, tx_q;
  logic             ready_d, ready_q;
  logic             busy_d, busy_q;
  logic             bit_end;
  logic             baud_clr;

  // Counter is held at 0 while idle so START begins a full bit period.
  assign baud_clr = (state_q == StIdle);

  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (baud_clr),
    .bit_end_o(bit_end)
  );

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    idx_d   = idx_q;
    par_d   = par_q;

    unique case (state_q)
      StIdle: begin
        if (tx_valid_i) begin
          shift_d = tx_data_i;
          par_d   = PARITY_ODD ? ~^tx_data_i : ^tx_data_i;
          idx_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = StData;
        end
      end
      StData: begin
        if (bit_end) begin
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          if (idx_q == IdxW'(WIDTH - 1)) begin
            idx_d   = '0;
            state_d = PARITY_EN ? StParity : StStop;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      StParity: begin
        if (bit_end) begin
          idx_d   = '0;
          state_d = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (idx_q == IdxW'(STOP_BITS - 1)) begin
            idx_d   = '0;
            state_d = StIdle;
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Outputs are decoded from the next state so the registered versions
    // line up with the state register.
    unique case (state_d)
      StStart:  tx_d = 1'b0;
      StData:   tx_d = shift_d[WIDTH-1];
      StParity: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    ready_d = (state_d == StIdle);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      shift_q <= '0;
      idx_q   <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      idx_q   <= idx_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign tx_o       = tx_q;
  assign tx_ready_o = ready_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: three instances (even parity/1 stop, odd parity/2 stop,
// no parity/1 stop), all WIDTH=8, CLKS_PER_BIT=4, checked cycle by cycle
// against a frame model built from the bit sequence of each word.
module tb_uart_tx;

  localparam int Cpb = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] din [3];
  logic [2:0] vin;
  logic [2:0] tx_w;
  logic [2:0] ready_w;
  logic [2:0] busy_w;

  int checks;
  int failures;

  uart_tx #(.WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1'b1), .PARITY_ODD(1'b0),
            .STOP_BITS(1)) dut_even (
    .clk(clk), .rst_n(rst_n), .tx_data_i(din[0]), .tx_valid_i(vin[0]),
    .tx_ready_o(ready_w[0]), .tx_o(tx_w[0]), .busy_o(busy_w[0])
  );

  uart_tx #(.WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1'b1), .PARITY_ODD(1'b1),
            .STOP_BITS(2)) dut_odd (
    .clk(clk), .rst_n(rst_n), .tx_data_i(din[1]), .tx_valid_i(vin[1]),
    .tx_ready_o(ready_w[1]), .tx_o(tx_w[1]), .busy_o(busy_w[1])
  );

  uart_tx #(.WIDTH(8), .CLKS_PER_BIT(Cpb), .PARITY_EN(1'b0), .PARITY_ODD(1'b0),
            .STOP_BITS(1)) dut_nopar (
    .clk(clk), .rst_n(rst_n), .tx_data_i(din[2]), .tx_valid_i(vin[2]),
    .tx_ready_o(ready_w[2]), .tx_o(tx_w[2]), .busy_o(busy_w[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cfg_par(input int d);
    return (d == 2) ? 0 : 1;
  endfunction

  function automatic int cfg_odd(input int d);
    return (d == 1) ? 1 : 0;
  endfunction

  function automatic int cfg_stops(input int d);
    return (d == 1) ? 2 : 1;
  endfunction

  function automatic int frame_clks(input int d);
    return (1 + 8 + cfg_par(d) + cfg_stops(d)) * Cpb;
  endfunction

  // Value of the line during bit slot idx of a frame carrying data.
  function automatic logic exp_bit(input logic [7:0] data, input int d, input int idx);
    int ones;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return data[8-idx];
    if (cfg_par(d) == 1 && idx == 9) begin
      ones = $countones(data);
      return ((ones + cfg_odd(d)) % 2) == 1;
    end
    return 1'b1;
  endfunction

  task automatic check_idle(input int d, input string name);
    checks++;
    if ({tx_w[d], ready_w[d], busy_w[d]} !== 3'b110) begin
      failures++;
      $display("FAIL %s dut%0d tx/ready/busy=%b%b%b expected 110", name, d,
               tx_w[d], ready_w[d], busy_w[d]);
    end
  endtask

  task automatic check_cycle(input int d, input logic [7:0] data, input int k,
                             input string name);
    logic e;
    e = exp_bit(data, d, k / Cpb);
    checks++;
    if (tx_w[d] !== e) begin
      failures++;
      $display("FAIL %s dut%0d cycle %0d tx=%b expected %b", name, d, k, tx_w[d], e);
    end
    checks++;
    if ({ready_w[d], busy_w[d]} !== 2'b01) begin
      failures++;
      $display("FAIL %s_hs dut%0d cycle %0d ready/busy=%b%b expected 01", name, d, k,
               ready_w[d], busy_w[d]);
    end
  endtask

  // One complete frame; tx_data is scrambled every cycle after the handshake.
  task automatic run_frame(input int d, input logic [7:0] data, input string name);
    int f;
    f = frame_clks(d);
    @(negedge clk);
    check_idle(d, {name, "_pre"});
    din[d] = data;
    vin[d] = 1'b1;
    @(negedge clk);
    vin[d] = 1'b0;
    for (int k = 0; k < f; k++) begin
      check_cycle(d, data, k, name);
      din[d] = 8'($urandom);
      @(negedge clk);
    end
    check_idle(d, {name, "_end"});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    vin   = 3'b111;
    for (int i = 0; i < 3; i++) din[i] = 8'h00;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) check_idle(d, "reset");
    end
    vin   = 3'b000;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) check_idle(d, "post_reset");
    end
  endtask

  task automatic test_single_frame();
    run_frame(0, 8'hA5, "even_a5");
  endtask

  task automatic test_odd_two_stop();
    run_frame(1, 8'h07, "odd_07");
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      for (int d = 0; d < 3; d++) run_frame(d, 8'($urandom), "random");
    end
  endtask

  task automatic test_back_to_back();
    int f;
    f = frame_clks(2);
    @(negedge clk);
    din[2] = 8'h00;
    vin[2] = 1'b1;
    @(negedge clk);
    din[2] = 8'hFF;
    for (int k = 0; k < f; k++) begin
      check_cycle(2, 8'h00, k, "b2b_f1");
      @(negedge clk);
    end
    check_idle(2, "b2b_gap");
    @(negedge clk);
    vin[2] = 1'b0;
    for (int k = 0; k < f; k++) begin
      check_cycle(2, 8'hFF, k, "b2b_f2");
      @(negedge clk);
    end
    check_idle(2, "b2b_end");
  endtask

  task automatic test_mid_frame_reset();
    logic [7:0] data;
    data = 8'($urandom);
    @(negedge clk);
    din[0] = data;
    vin[0] = 1'b1;
    @(negedge clk);
    vin[0] = 1'b0;
    // Data bit 3 occupies cycles 16..19 of the frame.
    for (int k = 0; k < 17; k++) begin
      check_cycle(0, data, k, "midframe");
      din[0] = 8'($urandom);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    for (int d = 0; d < 3; d++) check_idle(d, "midreset");
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3 * Cpb; c++) begin
      @(negedge clk);
      check_idle(0, "after_midreset");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    vin      = 3'b000;
    for (int i = 0; i < 3; i++) din[i] = 8'h00;
    test_reset();
    test_single_frame();
    test_odd_two_stop();
    test_back_to_back();
    test_random();
    test_mid_frame_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
